// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and instruction memory (slave).
//
// Handshake:
//   Request : a fetch is accepted on a rising clock edge where imem_req && imem_ready.
//             While imem_req is high and not yet accepted, imem_addr is held stable.
//   Response: imem_rdata is valid on any rising edge where imem_rvalid is high; the
//             pulse may last a single cycle and exactly one response follows each
//             accepted request. No response may follow an accepted request once rst_n
//             has been asserted.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Program counter and instruction-fetch stage. Fetches one word per instruction,
// holds it for the decoder until consumed, then selects the next PC from PCSrc.
// A misaligned redirect parks the unit in TRAP until reset.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instr_fetch_unit_if.master        imem,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    output logic [31:0]               instruction_code,
    output logic [31:0]               pc,
    output logic [31:0]               pc_plus4,
    input  logic [1:0]                PCSrc,
    input  logic [31:0]               branch_target,
    input  logic [31:0]               jal_target,
    input  logic [31:0]               jalr_target,
    output logic                      fetch_misaligned,
    output logic [1:0]                state_dbg
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] next_pc;
    logic [31:0] jalr_aligned;
    logic        redirect_misaligned;
    logic        consume;

    assign pc_plus4            = pc + 32'd4;
    assign jalr_aligned        = jalr_target & ~32'h0000_0001;
    assign redirect_misaligned = |next_pc[1:0];
    assign consume             = (state == S_VALID) && instr_ready;

    // Next-PC selection; branch_taken is already folded into PCSrc by the control unit.
    always_comb begin
        next_pc = pc_plus4;
        case (PCSrc)
            2'd1:    next_pc = branch_target;
            2'd2:    next_pc = jal_target;
            2'd3:    next_pc = jalr_aligned;
            default: next_pc = pc_plus4;
        endcase
    end

    // State register; reset drops any in-flight fetch and restarts at RESET_PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; ready/rvalid are only looked at in the state that expects them.
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: if (imem.imem_ready)  state_nxt = S_WAIT;
            S_WAIT:  if (imem.imem_rvalid) state_nxt = S_VALID;
            S_VALID: if (instr_ready)      state_nxt = redirect_misaligned ? S_TRAP : S_FETCH;
            default: state_nxt = S_TRAP;
        endcase
    end

    // Outputs decoded from state; the request is held off while reset is asserted.
    always_comb begin
        imem.imem_req  = rst_n && (state == S_FETCH);
        imem.imem_addr = pc;
        instr_valid    = (state == S_VALID);
        state_dbg      = state;
    end

    // Datapath: capture the fetched word, advance the PC or raise the sticky trap flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc               <= RESET_PC;
            instruction_code <= NOP;
            fetch_misaligned <= 1'b0;
        end else begin
            if ((state == S_WAIT) && imem.imem_rvalid) begin
                instruction_code <= imem.imem_rdata;
            end
            if (consume) begin
                if (redirect_misaligned) begin
                    fetch_misaligned <= 1'b1;
                end else begin
                    pc <= next_pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed fetch/redirect/stall/trap/reset scenarios.
// The memory model and the output monitor share one process; the driver only
// issues stimulus and pushes expected fetch addresses and instructions.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction_code;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [1:0]  PCSrc;
    logic [31:0] branch_target;
    logic [31:0] jal_target;
    logic [31:0] jalr_target;
    logic        fetch_misaligned;
    logic [1:0]  state_dbg;

    instr_fetch_unit_if imem_bus ();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem             (imem_bus),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instruction_code (instruction_code),
        .pc               (pc),
        .pc_plus4         (pc_plus4),
        .PCSrc            (PCSrc),
        .branch_target    (branch_target),
        .jal_target       (jal_target),
        .jalr_target      (jalr_target),
        .fetch_misaligned (fetch_misaligned),
        .state_dbg        (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_addr_q[$];
    logic [95:0] exp_instr_q[$];   // {pc, instruction_code, pc_plus4}

    // memory model configuration (written by driver only)
    int cfg_ready_wait   = 0;
    int cfg_rvalid_delay = 0;
    int stray_count      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h0) return 32'h0000_0093;
        return {addr[23:0], 8'h13};
    endfunction

    // ---------------- memory model + monitor ----------------
    initial begin : mem_and_monitor
        bit          resp_pend   = 0;
        int          resp_cnt    = 0;
        logic [31:0] resp_addr   = '0;
        bit          req_seen    = 0;
        int          wait_left   = 0;
        bit          hold_active = 0;
        int          stray_done  = 0;
        logic [95:0] e;
        imem_bus.imem_ready  = 1'b1;
        imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                resp_pend   = 0;
                req_seen    = 0;
                hold_active = 0;
            end else begin
                if (instr_valid && instr_ready) begin
                    if (exp_instr_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_instr: got pc 0x%08h code 0x%08h, none expected", pc, instruction_code);
                    end else begin
                        e = exp_instr_q.pop_front();
                        check("instr_pc",    pc,               e[95:64]);
                        check("instr_code",  instruction_code, e[63:32]);
                        check("instr_pcp4",  pc_plus4,         e[31:0]);
                    end
                end
                if (imem_bus.imem_req) begin
                    if (hold_active && exp_addr_q.size() != 0)
                        check("addr_held", imem_bus.imem_addr, exp_addr_q[0]);
                    if (imem_bus.imem_ready) begin
                        if (exp_addr_q.size() == 0) begin
                            n_checks++; n_fail++;
                            $display("FAIL unexpected_fetch: got addr 0x%08h, none expected", imem_bus.imem_addr);
                        end else begin
                            check("fetch_addr", imem_bus.imem_addr, exp_addr_q.pop_front());
                        end
                        resp_pend   = 1;
                        resp_cnt    = cfg_rvalid_delay;
                        resp_addr   = imem_bus.imem_addr;
                        req_seen    = 0;
                        hold_active = 0;
                    end else begin
                        hold_active = 1;
                    end
                end else if (hold_active) begin
                    n_checks++; n_fail++;
                    $display("FAIL req_dropped: got req 0 expected 1 before acceptance");
                    hold_active = 0;
                end
            end
            @(posedge clk); #1;
            imem_bus.imem_rvalid = 1'b0;
            if (stray_done != stray_count) begin
                stray_done++;
                imem_bus.imem_rvalid = 1'b1;
                imem_bus.imem_rdata  = 32'hDEAD_BEEF;
            end else if (resp_pend) begin
                if (resp_cnt == 0) begin
                    imem_bus.imem_rvalid = 1'b1;
                    imem_bus.imem_rdata  = mem_word(resp_addr);
                    resp_pend = 0;
                end else begin
                    resp_cnt--;
                end
            end
            if (imem_bus.imem_req) begin
                if (!req_seen) begin
                    req_seen  = 1;
                    wait_left = cfg_ready_wait;
                end
                if (wait_left > 0) wait_left--;
                imem_bus.imem_ready = (wait_left == 0);
            end else begin
                imem_bus.imem_ready = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_fetch(input logic [31:0] addr, input logic [31:0] code, input logic [31:0] pcp4);
        exp_addr_q.push_back(addr);
        exp_instr_q.push_back({addr, code, pcp4});
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        exp_addr_q.delete();
        exp_instr_q.delete();
        @(posedge clk); #1;
        check("rst_req",        imem_bus.imem_req,  32'h0);
        check("rst_addr",       imem_bus.imem_addr, 32'h0);
        check("rst_valid",      instr_valid,        32'h0);
        check("rst_code",       instruction_code,   32'h0000_0013);
        check("rst_misaligned", fetch_misaligned,   32'h0);
        check("rst_pc",         pc,                 32'h0);
        check("rst_pcp4",       pc_plus4,           32'h4);
        check("rst_state",      state_dbg,          32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (instr_valid !== 1'b1 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("valid_timeout", instr_valid, 32'h1);
    endtask

    task automatic consume(input logic [1:0] src, input logic [31:0] tgt, input int hold, input bit stray);
        logic [95:0] e;
        wait_valid();
        for (int i = 0; i < hold; i++) begin
            if (stray && i == 0) stray_count++;
            @(posedge clk); #1;
            e = (exp_instr_q.size() != 0) ? exp_instr_q[0] : '0;
            check("hold_code",   instruction_code,  e[63:32]);
            check("hold_pc",     pc,                e[95:64]);
            check("hold_valid",  instr_valid,       32'h1);
            check("hold_no_req", imem_bus.imem_req, 32'h0);
        end
        PCSrc         = src;
        branch_target = (src == 2'd1) ? tgt : 32'h0000_0A00;
        jal_target    = (src == 2'd2) ? tgt : 32'h0000_0B00;
        jalr_target   = (src == 2'd3) ? tgt : 32'h0000_0C04;
        instr_ready   = 1'b1;
        @(posedge clk); #1;
        instr_ready   = 1'b0;
        PCSrc         = 2'd0;
    endtask

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #200000;
        n_checks++; n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin : driver
        int n;
        rst_n         = 1'b0;
        instr_ready   = 1'b0;
        PCSrc         = 2'd0;
        branch_target = '0;
        jal_target    = '0;
        jalr_target   = '0;

        // reset, then zero-wait fetch of 0x93 at address 0
        do_reset();
        push_fetch(32'h0, 32'h0000_0093, 32'h4);
        @(posedge clk); #1;
        check("lat_wait_state", state_dbg,   32'h1);
        check("lat_wait_valid", instr_valid, 32'h0);
        @(posedge clk); #1;
        check("lat_valid",      instr_valid,      32'h1);
        check("lat_code",       instruction_code, 32'h0000_0093);

        // sequential fetches 0x4, 0x8; pc 0x4 stalled five cycles
        push_fetch(32'h4, 32'h0000_0413, 32'h8);
        consume(2'd0, 32'h0, 0, 0);
        push_fetch(32'h8, 32'h0000_0813, 32'hC);
        consume(2'd0, 32'h0, 5, 0);

        // JAL to 0x100 with a slow memory: ready low 4 cycles, rvalid 3 cycles late
        wait_valid();
        cfg_ready_wait   = 5;
        cfg_rvalid_delay = 3;
        push_fetch(32'h100, 32'h0001_0013, 32'h104);
        consume(2'd2, 32'h100, 0, 0);

        // JALR 0x205 -> 0x204, with a stray rvalid while holding in VALID
        wait_valid();
        cfg_ready_wait   = 0;
        cfg_rvalid_delay = 0;
        push_fetch(32'h204, 32'h0002_0413, 32'h208);
        consume(2'd3, 32'h205, 3, 1);

        // JALR 0x206 is misaligned -> TRAP
        consume(2'd3, 32'h206, 0, 0);
        for (int i = 0; i < 4; i++) begin
            check("trap_no_req", imem_bus.imem_req, 32'h0);
            check("trap_valid",  instr_valid,       32'h0);
            check("trap_state",  state_dbg,         32'h3);
            @(posedge clk); #1;
        end
        check("trap_misaligned", fetch_misaligned, 32'h1);
        check("trap_pc",         pc,               32'h204);

        // reset pulsed while a fetch of 0x40 is outstanding in WAIT
        do_reset();
        push_fetch(32'h0, 32'h0000_0093, 32'h4);
        wait_valid();
        cfg_rvalid_delay = 3;
        push_fetch(32'h40, 32'h0000_4013, 32'h44);
        consume(2'd1, 32'h40, 0, 0);
        n = 0;
        while (state_dbg != 2'd1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_wait", state_dbg, 32'h1);
        cfg_rvalid_delay = 0;
        do_reset();

        // restart at 0, branch to 0xFFFF_FFFC, wrap to 0
        push_fetch(32'h0, 32'h0000_0093, 32'h4);
        push_fetch(32'hFFFF_FFFC, 32'hFFFF_FC13, 32'h0);
        consume(2'd1, 32'hFFFF_FFFC, 0, 0);
        push_fetch(32'h0, 32'h0000_0093, 32'h4);
        consume(2'd0, 32'h0, 0, 0);
        push_fetch(32'h4, 32'h0000_0413, 32'h8);
        consume(2'd0, 32'h0, 0, 0);
        wait_valid();
        check("end_pc",   pc,               32'h4);
        check("end_code", instruction_code, 32'h0000_0413);
        check("end_addr_q_empty", 32'(exp_addr_q.size()),  32'h0);
        check("end_instr_q_left", 32'(exp_instr_q.size()), 32'h1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
